// File: rtl/scp_attack_seq.sv
// rtl/scp_attack_seq.sv - staged intrusion sequencer driven by guard alerts and a tick timer
module scp_attack_seq #(
  parameter int NUM_STAGES  = 3,
  parameter int TIMER_W     = 6,
  parameter int STAGE_TICKS = 35,
  parameter int CHEAT_TICKS = 25,
  parameter int MAX_CHEATS  = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              green,
  input  logic                              yellow,
  input  logic                              red,
  input  logic                              tick,
  output logic [2:0]                        state,
  output logic [$clog2(NUM_STAGES+1)-1:0]   stage,
  output logic [NUM_STAGES-1:0]             attack,
  output logic [TIMER_W-1:0]                timer,
  output logic                              cheat_out,
  output logic                              connected,
  output logic                              failed
);

  localparam int SW = $clog2(NUM_STAGES + 1);
  // Cheat counter is at least two bits even when MAX_CHEATS is small.
  localparam int CW = ($clog2(MAX_CHEATS + 1) > 2) ? $clog2(MAX_CHEATS + 1) : 2;

  localparam logic [TIMER_W-1:0] STAGE_LAST  = TIMER_W'(STAGE_TICKS - 1);
  localparam logic [TIMER_W-1:0] CHEAT_LAST  = TIMER_W'(CHEAT_TICKS - 1);
  localparam logic [SW-1:0]      STAGE_FULL  = SW'(NUM_STAGES);
  localparam logic [CW-1:0]      CHEAT_LIMIT = CW'(MAX_CHEATS);

  typedef enum logic [2:0] {
    S_LAY_LOW = 3'd0,
    S_CHEAT   = 3'd1,
    S_ATTACK  = 3'd2,
    S_FAIL    = 3'd4,
    S_CONNECT = 3'd5
  } state_t;

  state_t              r_state;
  logic [SW-1:0]       r_stage;
  logic [NUM_STAGES-1:0] r_attack;
  logic [TIMER_W-1:0]  r_timer;
  logic [CW-1:0]       r_cheat_count;
  logic                r_cheat_out;
  logic                r_connected;
  logic                r_failed;

  state_t              w_nxt_state;
  logic [SW-1:0]       w_nxt_stage;
  logic [TIMER_W-1:0]  w_nxt_timer;
  logic [CW-1:0]       w_nxt_cheat_count;
  logic                w_nxt_cheat_out;
  logic                w_nxt_connected;
  logic                w_nxt_failed;
  logic                w_green_q;

  // The attack vector is always the thermometer image of the completed-stage count.
  function automatic logic [NUM_STAGES-1:0] therm(input logic [SW-1:0] s);
    logic [NUM_STAGES-1:0] t;
    t = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      t[i] = (i < int'(s));
    end
    return t;
  endfunction

  assign w_green_q = green & ~yellow & ~red;

  // Next-state and next-output decode; red beats yellow beats green.
  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_stage       = r_stage;
    w_nxt_timer       = r_timer;
    w_nxt_cheat_count = r_cheat_count;
    w_nxt_cheat_out   = r_cheat_out;
    w_nxt_connected   = r_connected;
    w_nxt_failed      = r_failed;
    case (r_state)
      S_LAY_LOW, S_ATTACK: begin
        if (red) begin
          if (r_cheat_count == CHEAT_LIMIT) begin
            w_nxt_state     = S_FAIL;
            w_nxt_failed    = 1'b1;
            w_nxt_stage     = '0;
            w_nxt_cheat_out = 1'b0;
          end else begin
            w_nxt_state       = S_CHEAT;
            w_nxt_cheat_count = r_cheat_count + 1'b1;
            w_nxt_timer       = '0;
            w_nxt_cheat_out   = 1'b1;
          end
        end else if (yellow) begin
          w_nxt_timer = '0;
          if (r_state == S_ATTACK) begin
            w_nxt_stage = r_stage - 1'b1;
            if (r_stage == SW'(1)) begin
              w_nxt_state = S_LAY_LOW;
            end
          end
        end else if (w_green_q && tick) begin
          if (r_timer == STAGE_LAST) begin
            w_nxt_timer = '0;
            w_nxt_stage = r_stage + 1'b1;
            if (r_stage + 1'b1 == STAGE_FULL) begin
              w_nxt_state     = S_CONNECT;
              w_nxt_connected = 1'b1;
            end else begin
              w_nxt_state = S_ATTACK;
            end
          end else begin
            w_nxt_timer = r_timer + 1'b1;
          end
        end
      end
      S_CHEAT: begin
        if (tick) begin
          if (r_timer == CHEAT_LAST) begin
            w_nxt_cheat_out = 1'b0;
            w_nxt_stage     = '0;
            if (red) begin
              w_nxt_state  = S_FAIL;
              w_nxt_failed = 1'b1;
            end else begin
              w_nxt_state = S_LAY_LOW;
              w_nxt_timer = '0;
            end
          end else begin
            w_nxt_timer = r_timer + 1'b1;
          end
        end
      end
      S_FAIL, S_CONNECT: begin
        w_nxt_state = r_state;
      end
      default: begin
        w_nxt_state = S_LAY_LOW;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_LAY_LOW;
      r_stage       <= '0;
      r_attack      <= '0;
      r_timer       <= '0;
      r_cheat_count <= '0;
      r_cheat_out   <= 1'b0;
      r_connected   <= 1'b0;
      r_failed      <= 1'b0;
    end else begin
      r_state       <= w_nxt_state;
      r_stage       <= w_nxt_stage;
      r_attack      <= therm(w_nxt_stage);
      r_timer       <= w_nxt_timer;
      r_cheat_count <= w_nxt_cheat_count;
      r_cheat_out   <= w_nxt_cheat_out;
      r_connected   <= w_nxt_connected;
      r_failed      <= w_nxt_failed;
    end
  end

  assign state     = r_state;
  assign stage     = r_stage;
  assign attack    = r_attack;
  assign timer     = r_timer;
  assign cheat_out = r_cheat_out;
  assign connected = r_connected;
  assign failed    = r_failed;

endmodule

// File: doc/scp_attack_seq.md
# scp_attack_seq

Parametrised successor to the SCP-079 breach controller. It sequences an intrusion through `NUM_STAGES` attack stages, driven by the green/yellow/red guard-alert inputs and an internal tick-driven timer. It adds three behaviours: multi-step fallback on yellow, a bounded cheat budget, and explicit terminal flags. It sits between the alert generator and the facility display/score logic. All outputs are registered.

## Interface
Parameters:
- `NUM_STAGES`, 3: attack stages before connect; legal range 2..8.
- `TIMER_W`, 6: internal timer width; must satisfy 2^TIMER_W > max(STAGE_TICKS, CHEAT_TICKS).
- `STAGE_TICKS`, 35: qualifying ticks needed to complete one stage; legal range ≥1.
- `CHEAT_TICKS`, 25: ticks spent in the cheat state; legal range ≥1.
- `MAX_CHEATS`, 2: cheat episodes tolerated; entering cheat with `MAX_CHEATS` already used goes to FAIL.

Ports:
- `clock`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high; dominates every other input.
- `green` / `yellow` / `red`  in  1 each  alert levels, sampled every edge.
- `tick`  in  1  timer enable (one-cycle strobe or tied high).
- `state`  out  3  LAY_LOW=0, CHEAT=1, ATTACK=2, FAIL=4, CONNECT=5.
- `stage`  out  $clog2(NUM_STAGES+1)  number of completed stages, 0..NUM_STAGES.
- `attack`  out  NUM_STAGES  bit k = stage k completed (thermometer code).
- `timer`  out  TIMER_W  current timer value.
- `cheat_out`  out  1  high while in CHEAT.
- `connected` / `failed`  out  1 each  terminal flags.

## Operation
- Input priority each cycle: red > yellow > green.
  - "Green-qualified" means green=1, yellow=0, red=0.
  - When no colour is asserted, the block holds state and timer.
- Reset values: state=LAY_LOW, stage=0, attack=0, timer=0, cheat_out=0, connected=0, failed=0, cheat_count=0.
- LAY_LOW:
  - Red: go to CHEAT (see cheat entry rule).
  - Yellow: clear timer and stay.
  - Green-qualified with tick: timer+1.
  - When timer==STAGE_TICKS-1 with tick: set attack[0], stage=1, clear timer, go to ATTACK.
- ATTACK (stage k, 1 ≤ k < NUM_STAGES):
  - Red: go to CHEAT.
  - Yellow: clear attack[k-1], stage=k-1, clear timer. If the new stage is 0, go to LAY_LOW.
  - Green-qualified with tick: timer+1.
  - When timer==STAGE_TICKS-1 with tick: set attack[k], stage=k+1, clear timer. If the new stage is NUM_STAGES, go to CONNECT.
- Cheat entry (from LAY_LOW or ATTACK on red):
  - If cheat_count==MAX_CHEATS: go directly to FAIL.
  - Otherwise: cheat_count+1, clear timer, cheat_out=1, go to CHEAT.
- CHEAT:
  - Timer increments on every tick, regardless of colour.
  - Red during CHEAT does not increment cheat_count.
  - When timer==CHEAT_TICKS-1 with tick:
    - If red=1 on that edge: go to FAIL.
    - Otherwise: go to LAY_LOW, attack=0, stage=0, timer=0, cheat_out=0.
- FAIL (terminal): failed=1, attack=0, stage=0, cheat_out=0. All inputs except reset are ignored.
- CONNECT (terminal): connected=1, attack all ones, stage=NUM_STAGES. All inputs except reset are ignored.
- The timer never wraps, because it clears at every threshold.
- cheat_count is internal, 2 bits minimum, and is cleared only by reset.

## Timing
- Latency: every output reflects the inputs sampled at edge n, visible after edge n.
- Combinational input-to-output paths: none.
- A threshold completes on the edge where timer==limit-1 and tick=1. A stage therefore takes exactly STAGE_TICKS qualifying ticks.
- A yellow on the same edge as a threshold tick wins: the block falls back and the stage is not completed.
- A red on the same edge as a threshold tick wins: the block goes to CHEAT.
- With tick=0, the timer freezes in all states. Colour transitions still act.
- Reset mid-operation, including in a terminal state, restores all reset values on the next edge.

## Test plan
All scenarios use NUM_STAGES=3, STAGE_TICKS=4, CHEAT_TICKS=3, MAX_CHEATS=2, tick=1 unless stated.
- Reset then green for 12 cycles -> attack=001 after edge 4, 011 after edge 8, 111 after edge 12; then state=5, connected=1, stage=3.
- Green for 8 cycles, then yellow for 1 cycle -> attack=001, stage=1, state=2, timer=0. A second yellow -> attack=000, state=0.
- Green for 3 cycles, then red for 1 cycle -> state=1, cheat_out=1, timer=0. Then no colour for 3 cycles -> state=0, cheat_out=0, attack=000 after the 3rd edge.
- Enter CHEAT and hold red for 3 cycles -> state=4, failed=1. Subsequent green for 20 cycles -> outputs unchanged.
- Two clean cheat episodes, then a third red -> state=4 on the next edge, cheat_out=0.
- In ATTACK with stage=1, timer=2, tick=0 and green held for 5 cycles -> timer stays 2. Then reset for 1 cycle -> all reset values.
